// File: rtl/lcd_bus_responder.sv
// lcd_bus_responder
// Display-side responder for an HD44780-style parallel LCD bus. The block
// samples RS/RW/E/DB through synchronizers, decodes writes on the falling
// edge of E, tracks the DDRAM address counter, the entry-mode direction and
// the busy flag, answers status reads and queues every accepted write into a
// first-word-fall-through event FIFO.

module lcd_bus_responder #(
    parameter int BUSY_CYCLES  = 1850,
    parameter int CLEAR_CYCLES = 76500,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_en,
    input  logic [7:0] lcd_data_in,
    output logic [7:0] lcd_data_out,
    output logic       lcd_data_oe,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic       evt_rs,
    output logic [7:0] evt_data,
    output logic [6:0] evt_addr,
    output logic       busy,
    output logic [6:0] ddram_addr,
    output logic       overflow,
    input  logic       clear_overflow
);

    localparam int MAX_CYC = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int EVT_W   = 16;

    localparam logic [CNT_W-1:0] BUSY_LOAD  = CNT_W'(BUSY_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [PTR_W:0]   DEPTH_CNT  = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    // Reset synchronizer and internal reset
    logic [1:0] rstSync_q;
    logic       rstInt_n;

    // Bus synchronizers
    logic [1:0] rsSync_q;
    logic [1:0] rwSync_q;
    logic [2:0] enSync_q;
    logic [7:0] dataSync1_q;
    logic [7:0] dataSync2_q;

    // Registered write detection
    logic       eFall;
    logic       wrStb_q;
    logic       wrRs_q;
    logic [7:0] wrData_q;

    // Display state
    logic [6:0]       addr_q;
    logic [6:0]       addr_d;
    logic             incDec_q;
    logic             incDec_d;
    logic [CNT_W-1:0] loadVal_d;
    logic [6:0]       evtAddr_d;
    state_t           state_q;
    logic [CNT_W-1:0] busyCnt_q;

    // Event FIFO
    logic [EVT_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [PTR_W:0]   count_q;
    logic             overflow_q;
    logic             fifoFull;
    logic             fifoPop;
    logic             fifoPush;
    logic             fifoDrop;
    logic [EVT_W-1:0] evtWord;
    logic [EVT_W-1:0] headWord;

    // Assert asynchronously, release two clocks after the external reset lifts
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rstSync_q <= 2'b00;
        end else begin
            rstSync_q <= {rstSync_q[0], 1'b1};
        end
    end

    assign rstInt_n = rstSync_q[1];

    // Two-stage synchronizers on every bus pin plus a third stage on E for edge detection
    always_ff @(posedge clk_clk or negedge rstInt_n) begin
        if (!rstInt_n) begin
            rsSync_q    <= '0;
            rwSync_q    <= '0;
            enSync_q    <= '0;
            dataSync1_q <= '0;
            dataSync2_q <= '0;
        end else begin
            rsSync_q    <= {rsSync_q[0], lcd_rs};
            rwSync_q    <= {rwSync_q[0], lcd_rw};
            enSync_q    <= {enSync_q[1:0], lcd_en};
            dataSync1_q <= lcd_data_in;
            dataSync2_q <= dataSync1_q;
        end
    end

    assign eFall = enSync_q[2] & ~enSync_q[1] & ~rwSync_q[1];

    // Capture a write on the falling edge of E along with the RS and data seen that cycle
    always_ff @(posedge clk_clk or negedge rstInt_n) begin
        if (!rstInt_n) begin
            wrStb_q  <= 1'b0;
            wrRs_q   <= 1'b0;
            wrData_q <= '0;
        end else begin
            wrStb_q <= eFall;
            if (eFall) begin
                wrRs_q   <= rsSync_q[1];
                wrData_q <= dataSync2_q;
            end
        end
    end

    // Decode the captured write into next address, direction, busy duration and event address
    always_comb begin
        addr_d    = addr_q;
        incDec_d  = incDec_q;
        loadVal_d = BUSY_LOAD;
        evtAddr_d = addr_q;
        if (wrStb_q) begin
            if (wrRs_q) begin
                evtAddr_d = addr_q;
                addr_d    = incDec_q ? (addr_q + 7'd1) : (addr_q - 7'd1);
            end else begin
                if (wrData_q == 8'h01) begin
                    addr_d    = 7'd0;
                    incDec_d  = 1'b1;
                    loadVal_d = CLEAR_LOAD;
                end else if (wrData_q[7:1] == 7'b0000001) begin
                    addr_d    = 7'd0;
                    loadVal_d = CLEAR_LOAD;
                end else if (wrData_q[7:2] == 6'b000001) begin
                    incDec_d = wrData_q[1];
                end else if (wrData_q[7]) begin
                    addr_d = wrData_q[6:0];
                end
                evtAddr_d = addr_d;
            end
        end
    end

    // Address counter and entry-mode direction
    always_ff @(posedge clk_clk or negedge rstInt_n) begin
        if (!rstInt_n) begin
            addr_q   <= 7'd0;
            incDec_q <= 1'b1;
        end else begin
            addr_q   <= addr_d;
            incDec_q <= incDec_d;
        end
    end

    // Busy FSM: any write (re)loads the countdown, expiry returns to idle
    always_ff @(posedge clk_clk or negedge rstInt_n) begin
        if (!rstInt_n) begin
            state_q   <= ST_IDLE;
            busyCnt_q <= '0;
        end else begin
            if (wrStb_q) begin
                state_q   <= ST_BUSY;
                busyCnt_q <= loadVal_d;
            end else begin
                case (state_q)
                    ST_BUSY: begin
                        if (busyCnt_q == '0) begin
                            state_q <= ST_IDLE;
                        end else begin
                            busyCnt_q <= busyCnt_q - 1'b1;
                        end
                    end
                    default: begin
                        busyCnt_q <= '0;
                    end
                endcase
            end
        end
    end

    assign fifoFull = (count_q == DEPTH_CNT);
    assign fifoPop  = evt_valid & evt_ready;
    assign fifoPush = wrStb_q & (~fifoFull | fifoPop);
    assign fifoDrop = wrStb_q & fifoFull & ~fifoPop;
    assign evtWord  = {wrRs_q, wrData_q, evtAddr_d};
    assign headWord = mem_q[rdPtr_q];

    // Event storage; contents only matter where the occupancy count says so
    always_ff @(posedge clk_clk) begin
        if (fifoPush) begin
            mem_q[wrPtr_q] <= evtWord;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_clk or negedge rstInt_n) begin
        if (!rstInt_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (fifoPush) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (fifoPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({fifoPush, fifoPop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky overflow flag; a drop wins over a simultaneous clear
    always_ff @(posedge clk_clk or negedge rstInt_n) begin
        if (!rstInt_n) begin
            overflow_q <= 1'b0;
        end else if (fifoDrop) begin
            overflow_q <= 1'b1;
        end else if (clear_overflow) begin
            overflow_q <= 1'b0;
        end
    end

    assign evt_valid = (count_q != '0);
    assign evt_rs    = evt_valid ? headWord[15]   : 1'b0;
    assign evt_data  = evt_valid ? headWord[14:7] : 8'h00;
    assign evt_addr  = evt_valid ? headWord[6:0]  : 7'h00;

    assign busy       = (state_q == ST_BUSY);
    assign ddram_addr = addr_q;
    assign overflow   = overflow_q;

    assign lcd_data_oe  = enSync_q[1] & rwSync_q[1];
    assign lcd_data_out = (lcd_data_oe && !rsSync_q[1]) ? {busy, addr_q} : 8'h00;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Testbench for lcd_bus_responder: randomized bus writes and reads against a
// behavioural display model, with a scoreboard queue of expected events that
// a separate monitor drains whenever the event FIFO hands one over.

module tb_lcd_bus_responder;

    localparam int BUSY = 24;
    localparam int CLEAR = 90;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
        logic [6:0] addr;
    } evt_t;

    logic       clk_clk;
    logic       reset_reset_n;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic [7:0] lcd_data_in;
    logic [7:0] lcd_data_out;
    logic       lcd_data_oe;
    logic       evt_valid;
    logic       evt_ready;
    logic       evt_rs;
    logic [7:0] evt_data;
    logic [6:0] evt_addr;
    logic       busy;
    logic [6:0] ddram_addr;
    logic       overflow;
    logic       clear_overflow;

    int   errors = 0;
    int   checks = 0;
    evt_t expQ[$];
    logic [6:0] mAddr;
    logic       mId;
    logic       mOvf;
    logic       holdReady;

    lcd_bus_responder #(
        .BUSY_CYCLES(BUSY),
        .CLEAR_CYCLES(CLEAR),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_clk(clk_clk),
        .reset_reset_n(reset_reset_n),
        .lcd_rs(lcd_rs),
        .lcd_rw(lcd_rw),
        .lcd_en(lcd_en),
        .lcd_data_in(lcd_data_in),
        .lcd_data_out(lcd_data_out),
        .lcd_data_oe(lcd_data_oe),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_rs(evt_rs),
        .evt_data(evt_data),
        .evt_addr(evt_addr),
        .busy(busy),
        .ddram_addr(ddram_addr),
        .overflow(overflow),
        .clear_overflow(clear_overflow)
    );

    // Free-running clock
    initial begin
        clk_clk = 1'b0;
        forever #5 clk_clk = ~clk_clk;
    end

    // Hard stop in case something never finishes
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Behavioural model of a write; returns the busy duration it should cause
    task automatic modelWrite(input logic rs, input logic [7:0] data, output int dur);
        evt_t e;
        dur = BUSY;
        if (rs) begin
            e = '{rs: 1'b1, data: data, addr: mAddr};
            mAddr = 7'((int'(mAddr) + (mId ? 1 : 127)) % 128);
        end else begin
            if (data == 8'h01) begin
                mAddr = 7'd0;
                mId = 1'b1;
                dur = CLEAR;
            end else if (data == 8'h02 || data == 8'h03) begin
                mAddr = 7'd0;
                dur = CLEAR;
            end else if (data >= 8'h04 && data <= 8'h07) begin
                mId = data[1];
            end else if (data >= 8'h80) begin
                mAddr = 7'(int'(data) - 128);
            end
            e = '{rs: 1'b0, data: data, addr: mAddr};
        end
        if (expQ.size() < DEPTH) expQ.push_back(e);
        else mOvf = 1'b1;
    endtask

    // Drive one bus write, update the model, check state after the update edge
    task automatic applyStimulus(input logic rs, input logic [7:0] data, input bit measure);
        int dur;
        int n;
        lcd_rs = rs;
        lcd_rw = 1'b0;
        lcd_data_in = data;
        repeat (3) @(posedge clk_clk);
        #1 lcd_en = 1'b1;
        repeat (4) @(posedge clk_clk);
        #1 lcd_en = 1'b0;
        modelWrite(rs, data, dur);
        repeat (4) @(posedge clk_clk);
        #1;
        checkOutput("busyAfterWrite", 32'(busy), 32'd1);
        checkOutput("ddramAddr", 32'(ddram_addr), 32'(mAddr));
        checkOutput("overflow", 32'(overflow), 32'(mOvf));
        if (measure) begin
            n = 0;
            while (busy === 1'b1 && n < dur + 10) begin
                n++;
                @(posedge clk_clk);
                #1;
            end
            checkOutput("busyDuration", 32'(n), 32'(dur));
        end
    endtask

    // Wait for the scoreboard to empty with the consumer enabled
    task automatic drain(input int limit);
        int n;
        holdReady = 1'b0;
        n = 0;
        while (expQ.size() != 0 && n < limit) begin
            @(posedge clk_clk);
            n++;
        end
        checkOutput("drainRemaining", 32'(expQ.size()), 32'd0);
        repeat (3) @(posedge clk_clk);
        #1;
    endtask

    // Consumer: randomly accepts events unless held off
    initial begin
        evt_ready = 1'b0;
        forever begin
            @(posedge clk_clk);
            #1 evt_ready = holdReady ? 1'b0 : 1'($urandom_range(0, 1));
        end
    end

    // Monitor: on every handshake, pop the expected event and compare
    initial begin
        evt_t exp;
        forever begin
            @(negedge clk_clk);
            if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedEvent: got rs=%0d data=0x%0h addr=0x%0h expected none",
                             evt_rs, evt_data, evt_addr);
                end else begin
                    exp = expQ.pop_front();
                    checkOutput("eventHead", 32'({evt_rs, evt_data, evt_addr}), 32'(exp));
                end
            end
        end
    end

    // Main sequence
    initial begin
        int n;
        logic rs;
        logic [7:0] d;
        holdReady = 1'b1;
        lcd_rs = 1'b0;
        lcd_rw = 1'b0;
        lcd_en = 1'b0;
        lcd_data_in = 8'h00;
        clear_overflow = 1'b0;
        mAddr = 7'd0;
        mId = 1'b1;
        mOvf = 1'b0;
        reset_reset_n = 1'b0;
        repeat (4) @(posedge clk_clk);
        #1;
        checkOutput("resetBusy", 32'(busy), 32'd0);
        checkOutput("resetValid", 32'(evt_valid), 32'd0);
        checkOutput("resetAddr", 32'(ddram_addr), 32'd0);
        checkOutput("resetOe", 32'(lcd_data_oe), 32'd0);
        checkOutput("resetOvf", 32'(overflow), 32'd0);
        reset_reset_n = 1'b1;
        repeat (5) @(posedge clk_clk);
        #1 holdReady = 1'b0;

        // Clear display, exact long busy window
        applyStimulus(1'b0, 8'h01, 1'b1);

        // Set address 0x40 then two data bytes
        applyStimulus(1'b0, 8'hC0, 1'b0);
        applyStimulus(1'b1, 8'h41, 1'b0);
        applyStimulus(1'b1, 8'h42, 1'b1);

        // Decrement mode wrap below zero, then increment wrap above 0x7F
        applyStimulus(1'b0, 8'h04, 1'b0);
        applyStimulus(1'b0, 8'h80, 1'b0);
        applyStimulus(1'b1, 8'h55, 1'b0);
        applyStimulus(1'b0, 8'h06, 1'b0);
        applyStimulus(1'b0, 8'hFF, 1'b0);
        applyStimulus(1'b1, 8'h66, 1'b0);

        // Write while busy reloads with the new (short) duration
        applyStimulus(1'b0, 8'h02, 1'b0);
        applyStimulus(1'b1, 8'h77, 1'b1);

        // Status read during and after busy, then a data read
        applyStimulus(1'b0, 8'hA5, 1'b0);
        lcd_rs = 1'b0;
        lcd_rw = 1'b1;
        repeat (3) @(posedge clk_clk);
        #1 lcd_en = 1'b1;
        repeat (3) @(posedge clk_clk);
        #1;
        checkOutput("readOeBusy", 32'(lcd_data_oe), 32'd1);
        checkOutput("readStatusBusy", 32'(lcd_data_out), 32'hA5);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(posedge clk_clk);
            #1;
            n++;
        end
        @(posedge clk_clk);
        #1;
        checkOutput("readStatusIdle", 32'(lcd_data_out), 32'h25);
        lcd_en = 1'b0;
        repeat (3) @(posedge clk_clk);
        #1;
        checkOutput("readOeOff", 32'(lcd_data_oe), 32'd0);
        lcd_rs = 1'b1;
        repeat (3) @(posedge clk_clk);
        #1 lcd_en = 1'b1;
        repeat (3) @(posedge clk_clk);
        #1;
        checkOutput("readDataOe", 32'(lcd_data_oe), 32'd1);
        checkOutput("readDataValue", 32'(lcd_data_out), 32'h00);
        lcd_en = 1'b0;
        repeat (3) @(posedge clk_clk);
        #1;
        checkOutput("readNoState", 32'(ddram_addr), 32'h25);

        // Randomized writes
        for (int i = 0; i < 30; i++) begin
            rs = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            if (!rs) begin
                case ($urandom_range(0, 4))
                    0: d = 8'h01;
                    1: d = 8'h02 | (d & 8'h01);
                    2: d = 8'h04 | (d & 8'h03);
                    3: d = 8'h80 | d;
                    default: d = d;
                endcase
            end
            applyStimulus(rs, d, (i % 8) == 0);
        end

        // Overflow: nine writes with the consumer stalled
        drain(500);
        holdReady = 1'b1;
        repeat (2) @(posedge clk_clk);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 8'($urandom), 1'b0);
        end
        checkOutput("overflowSet", 32'(overflow), 32'd1);
        checkOutput("fullValid", 32'(evt_valid), 32'd1);
        clear_overflow = 1'b1;
        @(posedge clk_clk);
        #1 clear_overflow = 1'b0;
        mOvf = 1'b0;
        checkOutput("overflowCleared", 32'(overflow), 32'd0);
        drain(500);

        // Reset mid-busy with events pending
        holdReady = 1'b1;
        repeat (2) @(posedge clk_clk);
        applyStimulus(1'b0, 8'h04, 1'b0);
        applyStimulus(1'b1, 8'h11, 1'b0);
        applyStimulus(1'b1, 8'h22, 1'b0);
        #2 reset_reset_n = 1'b0;
        #1;
        checkOutput("asyncRstBusy", 32'(busy), 32'd0);
        checkOutput("asyncRstValid", 32'(evt_valid), 32'd0);
        checkOutput("asyncRstAddr", 32'(ddram_addr), 32'd0);
        checkOutput("asyncRstOvf", 32'(overflow), 32'd0);
        expQ.delete();
        mAddr = 7'd0;
        mId = 1'b1;
        mOvf = 1'b0;
        repeat (3) @(posedge clk_clk);
        #1 reset_reset_n = 1'b1;
        repeat (5) @(posedge clk_clk);
        #1 holdReady = 1'b0;
        applyStimulus(1'b1, 8'h33, 1'b0);

        drain(500);
        checkOutput("endValid", 32'(evt_valid), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lcd_bus_responder.md
# lcd_bus_responder

Display-side end of the HD44780-style parallel LCD bus that the Nios II system drives through its LCD conduit (RS, RW, E, DB[7:0]). The block samples the bus, decodes instruction and data writes, and maintains the DDRAM address counter, the entry-mode direction and the busy flag. It answers busy-flag/address reads and pushes every accepted write into an event FIFO. Decoded traffic reaches a character-buffer or display model without a physical panel.

## Interface
- BUSY_CYCLES, 1850: busy duration after an ordinary write (37 us at 50 MHz).
- CLEAR_CYCLES, 76500: busy duration after clear/home (1.53 ms at 50 MHz).
- FIFO_DEPTH, 8: event FIFO entries; power of two, ≥2.

- clk_clk  in  1  system clock; sole clock domain.
- reset_reset_n  in  1  asynchronous, active-low reset.
- lcd_rs  in  1  register select: 0 = instruction, 1 = data.
- lcd_rw  in  1  0 = write, 1 = read.
- lcd_en  in  1  enable strobe; writes complete on its falling edge.
- lcd_data_in  in  8  DB[7:0] from the initiator.
- lcd_data_out  out  8  read-back value.
- lcd_data_oe  out  1  high while this block drives DB.
- evt_valid  out  1  FIFO head valid.
- evt_ready  in  1  consumer accepts the head.
- evt_rs  out  1  head RS value.
- evt_data  out  8  head byte.
- evt_addr  out  7  DDRAM address at time of write (data events); current address after the write (instruction events).
- busy  out  1  busy flag.
- ddram_addr  out  7  current address counter.
- overflow  out  1  sticky: an event was dropped.
- clear_overflow  in  1  synchronous clear of overflow.

## Operation
- lcd_rs, lcd_rw, lcd_en and lcd_data_in each pass through a 2-flop synchronizer. The edge detector uses a third register on E.
- A write is the falling edge of synchronized E with synchronized RW = 0. RS and data are taken from the synchronized stage on the detection cycle.
- Instruction decode (RS = 0), first match wins:
  - 0x01 clear: addr ← 0, I/D ← 1, busy for CLEAR_CYCLES.
  - 0x02/0x03 home: addr ← 0, busy for CLEAR_CYCLES.
  - 0x04–0x07 entry mode: I/D ← bit1, busy for BUSY_CYCLES.
  - 0x80–0xFF set DDRAM address: addr ← data[6:0], busy for BUSY_CYCLES.
  - Any other value: busy for BUSY_CYCLES, no other state change.
- Data write (RS = 1): the event records the current addr. addr then changes by +1 (I/D = 1) or −1 (I/D = 0), modulo 128: 0x7F+1 → 0x00 and 0x00−1 → 0x7F. Busy for BUSY_CYCLES.
- Writes are accepted while busy. The busy counter reloads with the new duration.
- Every accepted write (instruction or data) pushes {rs, data, addr} into a first-word-fall-through FIFO.
  - FIFO full: the event is dropped, state is still updated, and overflow is set.
  - A push and pop on the same cycle while full succeeds.
  - clear_overflow on the same cycle as a drop leaves overflow set.
- Busy FSM: IDLE → BUSY on any write, with counter loaded with the duration. BUSY decrements each cycle and returns to IDLE after the count expires. busy = (state == BUSY).
- Read (synchronized E high and RW = 1):
  - lcd_data_oe = 1.
  - lcd_data_out = {busy, ddram_addr} when RS = 0.
  - lcd_data_out = 0x00 when RS = 1; DDRAM read is not modeled.
  - Reads push no event and change no state.
- Reset (asynchronous assert, synchronous release): addr = 0, I/D = 1, state IDLE, FIFO empty, all synchronizers 0. All outputs are 0.

## Timing
- Pin E falls before edge k → write detected at edge k+2 → addr, I/D, busy counter and FIFO updated at edge k+3.
- evt_valid rises after edge k+3 if the FIFO was empty.
- busy is high for exactly N cycles after edge k+3, where N = BUSY_CYCLES or CLEAR_CYCLES.
- RS, RW and DB must be stable ≥3 clk_clk cycles before and ≥1 cycle after the E fall.
- E high must last ≥3 cycles; shorter pulses may be missed.
- lcd_data_oe asserts 2 cycles after pin E/RW qualify and drops 2 cycles after E falls or RW drops.
- FIFO handshake: transfer on evt_valid & evt_ready. The head is stable while evt_valid is high and evt_ready is low.
- Reset asserted mid-busy or mid-read: outputs clear immediately. A pending edge in the synchronizers is discarded.

## Test plan
- Reset, then write instruction 0x01 → event {rs 0, data 0x01, addr 0x00}; busy high for exactly 76500 cycles; ddram_addr = 0x00.
- Write 0xC0 (set address 0x40), then data 0x41 and 0x42 → events carry addr 0x40 and 0x41; ddram_addr = 0x42.
- Entry mode 0x04, set address 0x00, data 0x55 → event addr 0x00; ddram_addr = 0x7F. Then 0x06, set 0x7F, data → ddram_addr = 0x00.
- Read with RS = 0 during busy after set address 0x25 → lcd_data_out = 0xA5, lcd_data_oe = 1; after busy expires → 0x25. No event pushed.
- evt_ready held low, 9 writes with FIFO_DEPTH = 8 → 8 events retained in order, overflow = 1, ddram_addr reflects all 9. clear_overflow → 0.
- Assert reset_reset_n low mid-busy with FIFO non-empty → busy, evt_valid, ddram_addr and overflow = 0 asynchronously; next write after release behaves as from reset.
